// File: rtl/ansi_input_decoder_pkg.sv
// Shared ANSI input constants: key event codes, ASCII markers and decoder states.
package ansi_input_decoder_pkg;

  localparam logic [3:0] KEY_NONE    = 4'd0;
  localparam logic [3:0] KEY_CHAR    = 4'd1;
  localparam logic [3:0] KEY_UP      = 4'd2;
  localparam logic [3:0] KEY_DOWN    = 4'd3;
  localparam logic [3:0] KEY_RIGHT   = 4'd4;
  localparam logic [3:0] KEY_LEFT    = 4'd5;
  localparam logic [3:0] KEY_ESC     = 4'd6;
  localparam logic [3:0] KEY_CPR     = 4'd7;
  localparam logic [3:0] KEY_UNKNOWN = 4'd8;

  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_LBRK  = 8'h5B;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_SEMI  = 8'h3B;
  localparam logic [7:0] ASCII_R     = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ESC    = 3'd1,
    S_SS3    = 3'd2,
    S_CSI_P0 = 3'd3,
    S_CSI_P1 = 3'd4
  } state_e;

  // Arrow final byte to key code; KEY_NONE when the byte is not A..D.
  function automatic logic [3:0] arrow_code(input logic [7:0] b);
    logic [3:0] code;
    case (b)
      8'h41:   code = KEY_UP;
      8'h42:   code = KEY_DOWN;
      8'h43:   code = KEY_RIGHT;
      8'h44:   code = KEY_LEFT;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ansi_param_acc.sv
// Saturating decimal accumulator for one CSI parameter.
module ansi_param_acc #(
  parameter int unsigned PARAM_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [7:0] value,
  output logic       seen
);

  logic [7:0]  value_q, value_d;
  logic        seen_q, seen_d;
  logic [11:0] sum;

  // 12 bits hold 255*10+9 without wrapping, so the clamp sees the true value.
  always_comb begin
    sum     = {4'b0, value_q} * 12'd10 + {8'b0, digit};
    value_d = value_q;
    seen_d  = seen_q;
    if (clr) begin
      value_d = '0;
      seen_d  = 1'b0;
    end else if (digit_valid) begin
      value_d = (sum > 12'(PARAM_MAX)) ? 8'(PARAM_MAX) : sum[7:0];
      seen_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      seen_q  <= seen_d;
    end
  end

  assign value = value_q;
  assign seen  = seen_q;

endmodule

// File: rtl/ansi_input_decoder.sv
// Terminal byte-stream decoder: plain chars, CSI/SS3 arrows, lone ESC and cursor-position reports.
module ansi_input_decoder
  import ansi_input_decoder_pkg::*;
#(
  parameter int unsigned ESC_TIMEOUT = 16,
  parameter int unsigned PARAM_MAX   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] key_char,
  output logic [7:0] key_p0,
  output logic [7:0] key_p1
);

  localparam int unsigned TimerW = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(ESC_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              extra_q, extra_d;

  logic       acc_clr, dv0, dv1;
  logic [7:0] p0, p1;
  logic       seen0, seen1;

  logic       emit;
  logic [3:0] emit_code;
  logic [7:0] emit_char, emit_p0, emit_p1;

  logic       is_digit, is_final;
  logic [3:0] arrow;

  ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc_p0 (
    .clk         (clk),
    .rst         (rst),
    .clr         (acc_clr),
    .digit_valid (dv0),
    .digit       (in_byte[3:0]),
    .value       (p0),
    .seen        (seen0)
  );

  ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_acc_p1 (
    .clk         (clk),
    .rst         (rst),
    .clr         (acc_clr),
    .digit_valid (dv1),
    .digit       (in_byte[3:0]),
    .value       (p1),
    .seen        (seen1)
  );

  assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign is_final = (in_byte >= 8'h40) && (in_byte <= 8'h7E);
  assign arrow    = arrow_code(in_byte);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    extra_d   = extra_q;
    acc_clr   = 1'b0;
    dv0       = 1'b0;
    dv1       = 1'b0;
    emit      = 1'b0;
    emit_code = KEY_NONE;
    emit_char = '0;
    emit_p0   = '0;
    emit_p1   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_byte == ASCII_ESC) begin
            state_d = S_ESC;
            timer_d = '0;
          end else begin
            emit      = 1'b1;
            emit_code = KEY_CHAR;
            emit_char = in_byte;
          end
        end
      end
      S_ESC: begin
        // A byte on the expiry cycle takes priority over the timeout.
        if (in_valid) begin
          timer_d = '0;
          if (in_byte == ASCII_LBRK) begin
            state_d = S_CSI_P0;
            acc_clr = 1'b1;
            extra_d = 1'b0;
          end else if (in_byte == ASCII_O) begin
            state_d = S_SS3;
          end else begin
            emit      = 1'b1;
            emit_code = KEY_ESC;
            state_d   = (in_byte == ASCII_ESC) ? S_ESC : S_IDLE;
          end
        end else if (timer_q == TimerLast) begin
          emit      = 1'b1;
          emit_code = KEY_ESC;
          state_d   = S_IDLE;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      S_SS3: begin
        if (in_valid) begin
          state_d = S_IDLE;
          emit    = 1'b1;
          if (arrow != KEY_NONE) begin
            emit_code = arrow;
          end else begin
            emit_code = KEY_UNKNOWN;
            emit_char = in_byte;
          end
        end
      end
      S_CSI_P0, S_CSI_P1: begin
        if (in_valid) begin
          if (is_digit) begin
            dv0 = (state_q == S_CSI_P0);
            dv1 = (state_q == S_CSI_P1) && !extra_q;
          end else if (in_byte == ASCII_SEMI) begin
            // A second ';' starts a third parameter whose digits are discarded.
            if (state_q == S_CSI_P1) extra_d = 1'b1;
            state_d = S_CSI_P1;
          end else if (in_byte == ASCII_ESC) begin
            emit      = 1'b1;
            emit_code = KEY_UNKNOWN;
            emit_char = in_byte;
            state_d   = S_ESC;
            timer_d   = '0;
          end else if (is_final) begin
            state_d = S_IDLE;
            emit    = 1'b1;
            if (arrow != KEY_NONE) begin
              emit_code = arrow;
              emit_p0   = p0;
              emit_p1   = p1;
            end else if (in_byte == ASCII_R) begin
              emit_code = KEY_CPR;
              emit_p0   = seen0 ? p0 : 8'd1;
              emit_p1   = seen1 ? p1 : 8'd1;
            end else begin
              emit_code = KEY_UNKNOWN;
              emit_char = in_byte;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      extra_q   <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= KEY_NONE;
      key_char  <= '0;
      key_p0    <= '0;
      key_p1    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      extra_q   <= extra_d;
      key_valid <= emit;
      if (emit) begin
        key_code <= emit_code;
        key_char <= emit_char;
        key_p0   <= emit_p0;
        key_p1   <= emit_p1;
      end
    end
  end

endmodule

// File: tb/tb_ansi_input_decoder.sv
// Scoreboard bench for ansi_input_decoder: directed byte sequences with hand-computed key events.
module tb_ansi_input_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] key_char;
  logic [7:0] key_p0;
  logic [7:0] key_p1;

  ansi_input_decoder #(.ESC_TIMEOUT(16), .PARAM_MAX(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_char  (key_char),
    .key_p0    (key_p0),
    .key_p1    (key_p1)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [7:0] ch;
    logic [7:0] p0;
    logic [7:0] p1;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   ev_n  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every key_valid pulse must match the oldest expected event, on its cycle.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got code=%0d char=%02h p0=%0d p1=%0d cyc=%0d, want none",
                 key_code, key_char, key_p0, key_p1, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (key_code !== e.code || key_char !== e.ch || key_p0 !== e.p0 ||
            key_p1 !== e.p1 || cyc != e.cyc) begin
          bad++;
          $display("FAIL event%0d: got code=%0d char=%02h p0=%0d p1=%0d cyc=%0d, want code=%0d char=%02h p0=%0d p1=%0d cyc=%0d",
                   ev_n, key_code, key_char, key_p0, key_p1, cyc,
                   e.code, e.ch, e.p0, e.p1, e.cyc);
        end
      end
      ev_n++;
    end
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  // Expect an event dly cycles after the byte driven now is consumed (dly=0: same edge).
  task automatic expect_ev(input logic [3:0] code, input logic [7:0] ch, input logic [7:0] p0,
                           input logic [7:0] p1, input int dly);
    exp_t e;
    e.code = code;
    e.ch   = ch;
    e.p0   = p0;
    e.p1   = p1;
    e.cyc  = cyc + 1 + dly;
    exp_q.push_back(e);
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [3:0] code, input logic [7:0] ch,
                          input logic [7:0] p0, input logic [7:0] p1);
    expect_ev(code, ch, p0, p1, 0);
    send(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({key_valid, key_code, key_char, key_p0, key_p1} !== '0) begin
      bad++;
      $display("FAIL %s: got valid=%0b code=%0d char=%02h p0=%0d p1=%0d, want all zero",
               name, key_valid, key_code, key_char, key_p0, key_p1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    idle(3);
    check_zero("reset_state");
    rst = 1'b0;
    idle(2);

    // Plain character, then silence
    send_exp(8'h61, 4'd1, 8'h61, 8'd0, 8'd0);
    idle(5);

    // CSI and SS3 arrows
    send(8'h1B); send(8'h5B);
    send_exp(8'h41, 4'd2, 8'h00, 8'd0, 8'd0);
    send(8'h1B); send(8'h4F);
    send_exp(8'h44, 4'd5, 8'h00, 8'd0, 8'd0);

    // Cursor position reports
    send(8'h1B); send(8'h5B); send_str("12;34");
    send_exp(8'h52, 4'd7, 8'h00, 8'd12, 8'd34);
    send(8'h1B); send(8'h5B);
    send_exp(8'h52, 4'd7, 8'h00, 8'd1, 8'd1);
    send(8'h1B); send(8'h5B); send_str(";5");
    send_exp(8'h52, 4'd7, 8'h00, 8'd1, 8'd5);

    // Lone ESC times out 16 cycles after the byte is consumed
    expect_ev(4'd6, 8'h00, 8'd0, 8'd0, 16);
    send(8'h1B);
    idle(20);

    // '[' on the expiry cycle continues the sequence instead
    send(8'h1B);
    idle(15);
    send(8'h5B);
    send_exp(8'h43, 4'd4, 8'h00, 8'd0, 8'd0);
    idle(20);

    // Saturating parameter
    send(8'h1B); send(8'h5B); send_str("999");
    send_exp(8'h41, 4'd2, 8'h00, 8'd255, 8'd0);

    // ESC inside CSI aborts it, then a fresh sequence
    send(8'h1B); send(8'h5B); send(8'h31);
    send_exp(8'h1B, 4'd8, 8'h1B, 8'd0, 8'd0);
    send(8'h5B);
    send_exp(8'h42, 4'd3, 8'h00, 8'd0, 8'd0);

    // ESC ESC, ESC + other byte (dropped), then back to plain chars
    send(8'h1B);
    send_exp(8'h1B, 4'd6, 8'h00, 8'd0, 8'd0);
    send_exp(8'h78, 4'd6, 8'h00, 8'd0, 8'd0);
    send_exp(8'h62, 4'd1, 8'h62, 8'd0, 8'd0);
    send_exp(8'h00, 4'd1, 8'h00, 8'd0, 8'd0);

    // SS3 unknown, CSI unknown final with intermediate, third parameter discarded
    send(8'h1B); send(8'h4F);
    send_exp(8'h5A, 4'd8, 8'h5A, 8'd0, 8'd0);
    send(8'h1B); send(8'h5B); send(8'h32); send(8'h20);
    send_exp(8'h7E, 4'd8, 8'h7E, 8'd0, 8'd0);
    send(8'h1B); send(8'h5B); send_str("5;6;7");
    send_exp(8'h43, 4'd4, 8'h00, 8'd5, 8'd6);
    idle(3);

    // Reset mid-sequence discards it
    send(8'h1B); send(8'h5B); send(8'h33);
    rst = 1'b1;
    #1;
    check_zero("reset_mid_seq");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_exp(8'h41, 4'd1, 8'h41, 8'd0, 8'd0);

    // Drain: every expected event must have arrived within a bounded wait
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got none, want code=%0d char=%02h p0=%0d p1=%0d cyc=%0d",
               e.code, e.ch, e.p0, e.p1, e.cyc);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
